traffic_detector: RTL and testbench

Two-lane vehicle detector that produces the `TA`/`TB` traffic-present inputs consumed by the intersection light controller. Each lane has a raw inductive-loop input. The block synchronises that input, debounces it, bridges short gaps between vehicles, and flags loops stuck high so the controller is never starved. Per-lane saturating vehicle counters are provided for statistics.

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/traffic_detector_channel.sv | 154 +++++++++++++++
 rtl/traffic_detector.sv | 61 ++++++
 tb/tb_traffic_detector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Package  : traffic_pkg
// Brief    : Shared types for the intersection controller and its detectors.
// Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    PRESENT = 3'd2,
    GAP     = 3'd3,
    FAULT   = 3'd4
  } det_state_t;

  localparam int c_LIGHT_W = 2;

  typedef enum logic [c_LIGHT_W-1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2
  } light_t;

endpackage
`default_nettype wire

// File: rtl/traffic_detector_channel.sv
`default_nettype none
// ============================================================================
// Module   : traffic_detector_channel
// Brief    : One lane: loop synchroniser, debounce/gap/stuck FSM and counter.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_detector_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE     = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int MAX_PRESENCE = 4096,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loop_raw,
  input  logic             clear_count,
  output logic             present,
  output logic             fault,
  output logic [CNT_W-1:0] vehicle_cnt
);

  localparam int c_QW = $clog2(DEBOUNCE + 1);
  localparam int c_GW = $clog2(GAP_CYCLES + 1);
  localparam int c_PW = $clog2(MAX_PRESENCE + 1);

  localparam logic [c_QW-1:0]  c_Q_LAST  = c_QW'(DEBOUNCE - 1);
  localparam logic [c_GW-1:0]  c_G_LAST  = c_GW'(GAP_CYCLES);
  localparam logic [c_PW-1:0]  c_P_LAST  = c_PW'(MAX_PRESENCE - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic             r_sync_meta;
  logic             r_raw_s;
  det_state_t       r_state;
  det_state_t       w_next_state;
  logic [c_QW-1:0]  r_qcnt;
  logic [c_GW-1:0]  r_gcnt;
  logic [c_PW-1:0]  r_ptime;
  logic [CNT_W-1:0] r_cnt;
  logic             r_present;
  logic             r_fault;
  logic             w_qualified;
  logic             w_present_next;
  logic             w_fault_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_meta <= 1'b0;
      r_raw_s     <= 1'b0;
    end else begin
      r_sync_meta <= loop_raw;
      r_raw_s     <= r_sync_meta;
    end
  end

  // State register; outputs are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_present <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_present <= w_present_next;
      r_fault   <= w_fault_next;
    end
  end

  // Presence timeout overrides every other PRESENT/GAP transition.
  always_comb begin
    w_next_state = r_state;
    w_qualified  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_raw_s) w_next_state = QUALIFY;
      end
      QUALIFY: begin
        if (!r_raw_s) begin
          w_next_state = IDLE;
        end else if (r_qcnt == c_Q_LAST) begin
          w_next_state = PRESENT;
          w_qualified  = 1'b1;
        end
      end
      PRESENT: begin
        if (r_ptime == c_P_LAST) w_next_state = FAULT;
        else if (!r_raw_s)       w_next_state = GAP;
      end
      GAP: begin
        if (r_ptime == c_P_LAST)      w_next_state = FAULT;
        else if (r_raw_s)             w_next_state = PRESENT;
        else if (r_gcnt == c_G_LAST)  w_next_state = IDLE;
      end
      FAULT: begin
        if (!r_raw_s && (r_qcnt == c_Q_LAST)) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_present_next = (w_next_state == PRESENT) || (w_next_state == GAP);
    w_fault_next   = (w_next_state == FAULT);
  end

  // r_qcnt serves as the qualify counter and the fault-release low counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_qcnt <= '0;
      r_gcnt <= '0;
    end else if (w_next_state != r_state) begin
      r_qcnt <= (w_next_state == QUALIFY) ? c_QW'(1) : '0;
      r_gcnt <= (w_next_state == GAP)     ? c_GW'(1) : '0;
    end else begin
      case (r_state)
        QUALIFY: r_qcnt <= r_qcnt + 1'b1;
        GAP:     r_gcnt <= r_gcnt + 1'b1;
        FAULT:   r_qcnt <= r_raw_s ? '0 : r_qcnt + 1'b1;
        default: begin
          r_qcnt <= r_qcnt;
          r_gcnt <= r_gcnt;
        end
      endcase
    end
  end

  // Timer survives GAP->PRESENT so a chain of short gaps still times out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptime <= '0;
    end else if (w_qualified) begin
      r_ptime <= '0;
    end else if ((r_state == PRESENT) || (r_state == GAP)) begin
      r_ptime <= r_ptime + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear_count) begin
      r_cnt <= '0;
    end else if (w_qualified && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign present     = r_present;
  assign fault       = r_fault;
  assign vehicle_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/traffic_detector.sv
`default_nettype none
// ============================================================================
// Module   : traffic_detector
// Brief    : Two-lane vehicle detector producing TA/TB for the light controller.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_detector
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE     = 4,
  parameter int GAP_CYCLES   = 8,
  parameter int MAX_PRESENCE = 4096,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             loop_a,
  input  logic             loop_b,
  input  logic             clear_counts,
  output logic             TA,
  output logic             TB,
  output logic             fault_a,
  output logic             fault_b,
  output logic [CNT_W-1:0] vehicle_cnt_a,
  output logic [CNT_W-1:0] vehicle_cnt_b
);

  logic [1:0]       w_loop;
  logic [1:0]       w_present;
  logic [1:0]       w_fault;
  logic [CNT_W-1:0] w_cnt [2];

  assign w_loop = {loop_b, loop_a};

  // Index 0 is lane A, index 1 is lane B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    traffic_detector_channel #(
      .DEBOUNCE     (DEBOUNCE),
      .GAP_CYCLES   (GAP_CYCLES),
      .MAX_PRESENCE (MAX_PRESENCE),
      .CNT_W        (CNT_W)
    ) u_channel (
      .clk         (clk),
      .reset       (reset),
      .loop_raw    (w_loop[gi]),
      .clear_count (clear_counts),
      .present     (w_present[gi]),
      .fault       (w_fault[gi]),
      .vehicle_cnt (w_cnt[gi])
    );
  end

  assign TA            = w_present[0];
  assign TB            = w_present[1];
  assign fault_a       = w_fault[0];
  assign fault_b       = w_fault[1];
  assign vehicle_cnt_a = w_cnt[0];
  assign vehicle_cnt_b = w_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_traffic_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_detector
// Brief    : Self-checking bench: vector table, directed corners, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_detector;

  localparam int DEB  = 4;
  localparam int GAP  = 8;
  localparam int MAXP = 64;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loop_a = 1'b0;
  logic loop_b = 1'b0;
  logic clear_counts = 1'b0;
  logic TA, TB, fault_a, fault_b;
  logic [CW-1:0] vehicle_cnt_a, vehicle_cnt_b;

  int total = 0;
  int bad   = 0;

  traffic_detector #(
    .DEBOUNCE(DEB), .GAP_CYCLES(GAP), .MAX_PRESENCE(MAXP), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .loop_a(loop_a), .loop_b(loop_b),
    .clear_counts(clear_counts), .TA(TA), .TB(TB), .fault_a(fault_a),
    .fault_b(fault_b), .vehicle_cnt_a(vehicle_cnt_a), .vehicle_cnt_b(vehicle_cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic la, lb, clr;
    int   reps;
    logic ta, tb, fa, fb;
    int   ca, cb;
  } vec_t;

  vec_t vecs[13];

  // Behavioural reference: run-length rules per lane, two-sample sync delay.
  bit m_s1[2], m_s2[2], m_pres[2], m_fault[2];
  int m_hi[2], m_lo[2], m_age[2], m_cnt[2];

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_s1[l] = 0; m_s2[l] = 0; m_pres[l] = 0; m_fault[l] = 0;
      m_hi[l] = 0; m_lo[l] = 0; m_age[l] = 0; m_cnt[l] = 0;
    end
  endtask

  task automatic model_step(input logic la, input logic lb, input logic clr);
    bit lp[2];
    bit s, q;
    lp[0] = la; lp[1] = lb;
    for (int l = 0; l < 2; l++) begin
      s = m_s2[l]; m_s2[l] = m_s1[l]; m_s1[l] = lp[l]; q = 0;
      if (m_fault[l]) begin
        m_lo[l] = s ? 0 : m_lo[l] + 1;
        if (m_lo[l] >= DEB) begin m_fault[l] = 0; m_hi[l] = 0; end
      end else if (m_pres[l]) begin
        m_age[l]++;
        if (m_age[l] == MAXP) begin
          m_pres[l] = 0; m_fault[l] = 1; m_lo[l] = 0;
        end else if (s) begin
          m_lo[l] = 0;
        end else begin
          m_lo[l]++;
          if (m_lo[l] > GAP) begin m_pres[l] = 0; m_hi[l] = 0; end
        end
      end else begin
        m_hi[l] = s ? m_hi[l] + 1 : 0;
        if (m_hi[l] >= DEB) begin
          m_pres[l] = 1; m_age[l] = 0; m_lo[l] = 0; m_hi[l] = 0; q = 1;
        end
      end
      if (clr) m_cnt[l] = 0;
      else if (q && m_cnt[l] < CMAX) m_cnt[l]++;
    end
  endtask

  task automatic tick(input logic la, input logic lb, input logic clr);
    loop_a = la; loop_b = lb; clear_counts = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ta, input logic tb,
                            input logic fa, input logic fb, input int ca, input int cb);
    check({tag, "_TA"}, 32'(TA), 32'(ta));
    check({tag, "_TB"}, 32'(TB), 32'(tb));
    check({tag, "_fault_a"}, 32'(fault_a), 32'(fa));
    check({tag, "_fault_b"}, 32'(fault_b), 32'(fb));
    check({tag, "_cnt_a"}, 32'(vehicle_cnt_a), 32'(ca));
    check({tag, "_cnt_b"}, 32'(vehicle_cnt_b), 32'(cb));
  endtask

  initial begin
    int n;
    bit still_high;
    logic lvl[2];
    int run_left[2];
    logic clr;

    //            la lb clr reps ta tb fa fb ca cb
    vecs[0]  = '{1, 0, 0, 5,  0, 0, 0, 0, 0, 0};  // A qualifying
    vecs[1]  = '{1, 0, 0, 3,  1, 0, 0, 0, 1, 0};  // A present and counted
    vecs[2]  = '{0, 0, 0, 10, 1, 0, 0, 0, 1, 0};  // A gap hold
    vecs[3]  = '{0, 0, 0, 3,  0, 0, 0, 0, 1, 0};  // A departed
    vecs[4]  = '{1, 0, 0, 3,  0, 0, 0, 0, 1, 0};  // 3-cycle glitch
    vecs[5]  = '{0, 0, 0, 8,  0, 0, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 0, 5,  0, 0, 0, 0, 1, 0};  // B qualifying
    vecs[7]  = '{0, 1, 0, 3,  0, 1, 0, 0, 1, 1};
    vecs[8]  = '{0, 0, 0, 5,  0, 1, 0, 0, 1, 1};  // short gap bridged
    vecs[9]  = '{0, 1, 0, 4,  0, 1, 0, 0, 1, 1};  // not recounted
    vecs[10] = '{0, 0, 0, 10, 0, 1, 0, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 2,  0, 0, 0, 0, 1, 1};
    vecs[12] = '{0, 0, 1, 1,  0, 0, 0, 0, 0, 0};  // clear alone

    reset = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        tick(vecs[i].la, vecs[i].lb, vecs[i].clr);
        check_outs($sformatf("vec%0d_r%0d", i, r), vecs[i].ta, vecs[i].tb,
                   vecs[i].fa, vecs[i].fb, vecs[i].ca, vecs[i].cb);
      end
    end

    // Clear coinciding with lane A qualification wins.
    for (int k = 0; k < 5; k++) tick(1, 0, 0);
    tick(1, 0, 1);
    check("clr_qual_TA", 32'(TA), 32'd1);
    check("clr_qual_cnt_a", 32'(vehicle_cnt_a), 32'd0);
    tick(1, 0, 0);
    check("clr_qual_cnt_a_hold", 32'(vehicle_cnt_a), 32'd0);
    for (int k = 0; k < 12; k++) tick(0, 0, 0);
    check("clr_qual_TA_off", 32'(TA), 32'd0);

    // Stuck loop on lane A.
    for (int k = 0; k < 20 && TA !== 1'b1; k++) tick(1, 0, 0);
    check("stuck_TA_rise", 32'(TA), 32'd1);
    n = 1;
    still_high = 1;
    while (still_high && n < 200) begin
      tick(1, 0, 0);
      if (TA === 1'b1) n++;
      else still_high = 0;
    end
    check("stuck_TA_cycles", 32'(n), 32'(MAXP));
    check("stuck_fault_rise", 32'(fault_a), 32'd1);
    check("stuck_cnt_a", 32'(vehicle_cnt_a), 32'd1);
    for (int k = 0; k < 3; k++) tick(1, 0, 0);
    check("stuck_fault_hold", 32'(fault_a), 32'd1);
    check("stuck_TA_low", 32'(TA), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(0, 0, 0);
      check($sformatf("release_k%0d", k), 32'(fault_a), (k < 5) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 6; k++) begin
      tick(1, 0, 0);
      check($sformatf("rearrive_k%0d", k), 32'(TA), (k == 6) ? 32'd1 : 32'd0);
    end
    check("rearrive_cnt_a", 32'(vehicle_cnt_a), 32'd2);
    for (int k = 0; k < 12; k++) tick(0, 0, 0);

    // 300 minimum-length lane B vehicles; counter saturates.
    tick(0, 0, 1);
    for (int v = 1; v <= 300; v++) begin
      for (int k = 0; k < 4; k++) tick(0, 1, 0);
      for (int k = 0; k < 12; k++) tick(0, 0, 0);
      if (v == 3 || v == 100 || v == 255 || v == 256 || v == 300)
        check($sformatf("sat_v%0d", v), 32'(vehicle_cnt_b), 32'((v > CMAX) ? CMAX : v));
    end

    // Reset while A is PRESENT and B is in GAP.
    for (int k = 0; k < 11; k++) tick(1, (k < 7) ? 1'b1 : 1'b0, 0);
    check("pre_reset_TA", 32'(TA), 32'd1);
    check("pre_reset_TB", 32'(TB), 32'd1);
    reset = 1'b1;
    tick(1, 0, 0);
    reset = 1'b0;
    check_outs("midreset", 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      tick(1, 0, 0);
      check($sformatf("post_reset_k%0d", k), 32'(TA), (k == 6) ? 32'd1 : 32'd0);
    end
    check("post_reset_cnt_a", 32'(vehicle_cnt_a), 32'd1);

    // Random runs against the reference model.
    reset = 1'b1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    reset = 1'b0;
    model_reset();
    lvl[0] = 0; lvl[1] = 0;
    run_left[0] = 0; run_left[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int l = 0; l < 2; l++) begin
        if (run_left[l] == 0) begin
          int r;
          lvl[l] = ~lvl[l];
          r = int'($urandom_range(0, 99));
          if (r < 4)       run_left[l] = int'($urandom_range(66, 90));
          else if (r < 30) run_left[l] = int'($urandom_range(1, 4));
          else             run_left[l] = int'($urandom_range(1, 14));
        end
        run_left[l]--;
      end
      clr = ($urandom_range(0, 149) == 0);
      tick(lvl[0], lvl[1], clr);
      model_step(lvl[0], lvl[1], clr);
      check_outs($sformatf("rand%0d", c), m_pres[0], m_pres[1], m_fault[0], m_fault[1],
                 m_cnt[0], m_cnt[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
